// File: rtl/bullet_controller.sv
// Player bullet: fires on a button edge, climbs on a divided tick,
// ends on collision or at the screen top, then cools down.
module bullet_controller #(
  parameter int BULLET_W    = 2,
  parameter int BULLET_H    = 8,
  parameter int STEP        = 4,
  parameter int TICK_DIV    = 250000,
  parameter int COOL_CYCLES = 8,
  parameter int SCREEN_TOP  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fire,
  input  logic [10:0] ship_x,
  input  logic [10:0] ship_topy,
  input  logic        collide,
  output logic [43:0] bullet,
  output logic        active,
  output logic        hit,
  output logic        miss
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (COOL_CYCLES > 2) ? $clog2(COOL_CYCLES) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COOL_MAX = CW'(COOL_CYCLES - 1);
  localparam logic [10:0]   PARK     = 11'h7FF;
  localparam logic [10:0]   H        = 11'(BULLET_H);
  localparam logic [10:0]   W_M1     = 11'(BULLET_W - 1);
  localparam logic [10:0]   STP      = 11'(STEP);
  localparam logic [11:0]   MISS_LIM = 12'(SCREEN_TOP + STEP);

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    COOLDOWN
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [CW-1:0] cool_cnt;
  logic          fire_q;
  logic [10:0]   left;
  logic [10:0]   right;
  logic [10:0]   top;
  logic [10:0]   bottom;

  logic tick;
  logic fire_edge;
  logic spawn;
  logic at_top;

  assign tick      = (tick_cnt == TICK_MAX);
  assign fire_edge = fire & ~fire_q;
  assign spawn     = (state == IDLE) & fire_edge & (ship_topy >= H);
  assign at_top    = ({1'b0, top} < MISS_LIM);
  assign bullet    = {bottom, top, right, left};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      cool_cnt <= '0;
      fire_q   <= 1'b1;
      left     <= PARK;
      right    <= PARK;
      top      <= PARK;
      bottom   <= PARK;
      active   <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      fire_q <= fire;
      hit    <= 1'b0;
      miss   <= 1'b0;

      if (spawn || tick)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (spawn) begin
            left   <= ship_x;
            right  <= ship_x + W_M1;
            bottom <= ship_topy - 11'd1;
            top    <= ship_topy - H;
            active <= 1'b1;
            state  <= FLY;
          end
        end
        FLY: begin
          // collision wins over a same-cycle tick: no step is applied
          if (collide || (tick && at_top)) begin
            left     <= PARK;
            right    <= PARK;
            top      <= PARK;
            bottom   <= PARK;
            active   <= 1'b0;
            hit      <= collide;
            miss     <= ~collide;
            cool_cnt <= COOL_MAX;
            state    <= COOLDOWN;
          end else if (tick) begin
            top    <= top - STP;
            bottom <= bottom - STP;
          end
        end
        COOLDOWN: begin
          if (cool_cnt == '0)
            state <= IDLE;
          else
            cool_cnt <= cool_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed scoreboard bench for bullet_controller
// with TICK_DIV=4 and COOL_CYCLES=8.
module tb_bullet_controller;

  localparam logic [43:0] PARKED = 44'hFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fire;
  logic [10:0] ship_x;
  logic [10:0] ship_topy;
  logic        collide;
  logic [43:0] bullet;
  logic        active;
  logic        hit;
  logic        miss;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [43:0] b;
    logic        a;
    logic        h;
    logic        m;
  } exp_t;

  exp_t sb[$];

  bullet_controller #(
    .BULLET_W(2),
    .BULLET_H(8),
    .STEP(4),
    .TICK_DIV(4),
    .COOL_CYCLES(8),
    .SCREEN_TOP(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fire(fire),
    .ship_x(ship_x),
    .ship_topy(ship_topy),
    .collide(collide),
    .bullet(bullet),
    .active(active),
    .hit(hit),
    .miss(miss)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] box(int b, int t, int r, int l);
    return {11'(b), 11'(t), 11'(r), 11'(l)};
  endfunction

  task automatic check_out();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=%0d need=1", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      assert (bullet === e.b) else begin
        bad++;
        $error("FAIL %s bullet got=%h need=%h", e.tag, bullet, e.b);
      end
      total++;
      assert (active === e.a) else begin
        bad++;
        $error("FAIL %s active got=%b need=%b", e.tag, active, e.a);
      end
      total++;
      assert (hit === e.h) else begin
        bad++;
        $error("FAIL %s hit got=%b need=%b", e.tag, hit, e.h);
      end
      total++;
      assert (miss === e.m) else begin
        bad++;
        $error("FAIL %s miss got=%b need=%b", e.tag, miss, e.m);
      end
    end
  endtask

  // push the expectation for the coming edge, clock, then compare
  task automatic step(string tag, logic [43:0] b,
                      logic a, logic h, logic m);
    exp_t e;
    e.tag = tag;
    e.b   = b;
    e.a   = a;
    e.h   = h;
    e.m   = m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic park(string tag);
    step(tag, PARKED, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [43:0] b0;
    logic [43:0] b1;

    rst_n     = 1'b0;
    fire      = 1'b1;
    collide   = 1'b0;
    ship_x    = 11'd100;
    ship_topy = 11'd400;

    // reset with fire held
    park("rst0");
    park("rst1");
    park("rst2");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) park("held_fire");

    // spawn and first move
    b0 = box(399, 392, 101, 100);
    b1 = box(395, 388, 101, 100);
    fire = 1'b0;
    park("release");
    fire = 1'b1;
    step("spawn", b0, 1'b1, 1'b0, 1'b0);
    fire = 1'b0;
    step("fly1", b0, 1'b1, 1'b0, 1'b0);
    fire = 1'b1;
    step("fly_fire", b0, 1'b1, 1'b0, 1'b0);
    step("fly3", b0, 1'b1, 1'b0, 1'b0);
    step("move1", b1, 1'b1, 1'b0, 1'b0);
    step("after_move", b1, 1'b1, 1'b0, 1'b0);

    // plain hit, then fire edges through cooldown
    collide = 1'b1;
    step("hit", PARKED, 1'b0, 1'b1, 1'b0);
    collide = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      fire = (i % 2 == 1) ? 1'b1 : 1'b0;
      park("cool_fire");
    end

    // edge on first idle cycle; right x wraps
    ship_x    = 11'd2047;
    ship_topy = 11'd10;
    fire      = 1'b1;
    b0        = box(9, 2, 0, 2047);
    step("spawn_wrap", b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("fly_low", b0, 1'b1, 1'b0, 1'b0);
    step("miss", PARKED, 1'b0, 1'b0, 1'b1);
    fire = 1'b0;
    for (int i = 0; i < 8; i++) park("cool_miss");

    // ship too high on screen
    ship_topy = 11'd5;
    fire      = 1'b1;
    park("low_topy");
    fire = 1'b0;
    park("low_rel");

    // hit on the tick cycle
    ship_x    = 11'd100;
    ship_topy = 11'd400;
    fire      = 1'b1;
    b0        = box(399, 392, 101, 100);
    step("spawn2", b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("fly2", b0, 1'b1, 1'b0, 1'b0);
    collide = 1'b1;
    step("hit_tick", PARKED, 1'b0, 1'b1, 1'b0);
    collide = 1'b0;
    fire    = 1'b0;
    for (int i = 0; i < 8; i++) park("cool_hit");

    // mid-flight reset
    fire = 1'b1;
    step("spawn3", b0, 1'b1, 1'b0, 1'b0);
    step("fly_r", b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    park("mid_rst");
    rst_n = 1'b1;
    park("post_rst");
    park("post_rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
